// File: rtl/gcd_lcm_sequencer.sv
// Multi-cycle GCD/LCM engine that stalls the CPU while iterating and returns one regfile write.
// Optional overflow flag on the LCM multiply: define GCDLCM_OVF_EN to add the ovf port.
module gcd_lcm_sequencer #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [RD_W-1:0]  rd_in,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             rd_we,
  output logic [RD_W-1:0]  rd_out,
  output logic [WIDTH-1:0] result
`ifdef GCDLCM_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0]    I_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    I_ONE  = IW'(1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GCD  = 3'd1,
    DIV  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r, b_r, orig_a_r, orig_b_r, g_r, rem_r, q_r, acc_r;
  logic             op_r;
  logic [IW-1:0]    i_r;
  logic [WIDTH-1:0] addend_s, mul_acc_s;
`ifdef GCDLCM_OVF_EN
  logic [2*WIDTH-1:0] part_s;
  logic [WIDTH:0]     sum_s;
  logic               mul_ovf_s;
`endif

  // Stall includes the accept cycle so the CPU never advances past the instruction being issued.
  assign stall = ((state_r == IDLE) && start) ||
                 (state_r == GCD) || (state_r == DIV) || (state_r == MUL);
  assign busy  = (state_r != IDLE);
  assign done  = (state_r == DONE);
  assign rd_we = (state_r == DONE);

  // One shift-add multiply step: add orig_b << i when quotient bit i is set.
  always_comb begin
`ifdef GCDLCM_OVF_EN
    part_s    = {{WIDTH{1'b0}}, orig_b_r} << i_r;
    addend_s  = q_r[i_r] ? part_s[WIDTH-1:0] : ZERO;
    sum_s     = {1'b0, acc_r} + {1'b0, addend_s};
    mul_acc_s = sum_s[WIDTH-1:0];
    mul_ovf_s = q_r[i_r] && (sum_s[WIDTH] || (|part_s[2*WIDTH-1:WIDTH]));
`else
    addend_s  = q_r[i_r] ? (orig_b_r << i_r) : ZERO;
    mul_acc_s = acc_r + addend_s;
`endif
  end

  // Sequencer FSM with its datapath registers and registered result/rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      a_r      <= ZERO;
      b_r      <= ZERO;
      orig_a_r <= ZERO;
      orig_b_r <= ZERO;
      g_r      <= ZERO;
      rem_r    <= ZERO;
      q_r      <= ZERO;
      acc_r    <= ZERO;
      op_r     <= 1'b0;
      i_r      <= {IW{1'b0}};
      rd_out   <= {RD_W{1'b0}};
      result   <= ZERO;
`ifdef GCDLCM_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= rs1_val;
            b_r      <= rs2_val;
            orig_a_r <= rs1_val;
            orig_b_r <= rs2_val;
            op_r     <= op;
            rd_out   <= rd_in;
`ifdef GCDLCM_OVF_EN
            ovf      <= 1'b0;
`endif
            // A zero operand short-circuits: gcd(x,0) = x, lcm(x,0) = 0.
            if ((rs1_val == ZERO) || (rs2_val == ZERO)) begin
              result  <= op ? ZERO : (rs1_val | rs2_val);
              state_r <= DONE;
            end else begin
              result  <= ZERO;
              state_r <= GCD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        GCD: begin
          if (a_r > b_r) begin
            a_r <= a_r - b_r;
          end else if (b_r > a_r) begin
            b_r <= b_r - a_r;
          end else begin
            g_r <= a_r;
            if (op_r) begin
              rem_r   <= orig_a_r;
              q_r     <= ZERO;
              state_r <= DIV;
            end else begin
              result  <= a_r;
              state_r <= DONE;
            end
          end
        end
        DIV: begin
          if (rem_r >= g_r) begin
            rem_r <= rem_r - g_r;
            q_r   <= q_r + ONE;
          end else begin
            acc_r   <= ZERO;
            i_r     <= {IW{1'b0}};
            state_r <= MUL;
          end
        end
        MUL: begin
          acc_r <= mul_acc_s;
          i_r   <= i_r + I_ONE;
`ifdef GCDLCM_OVF_EN
          if (mul_ovf_s) begin
            ovf <= 1'b1;
          end
`endif
          if (i_r == I_LAST) begin
            result  <= mul_acc_s;
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
